line_fill_memory: RTL and testbench
===================================

// Module: line_fill_memory
// PURPOSE
// - Backing main memory for the 2-way set-associative cache; the cache's fill source.
// - Accepts a 6-bit line request and waits a fixed access latency.
// - Reads the four 32-bit words of the line one per cycle and returns a packed 128-bit line.
// - A word-write port preloads and updates memory contents.
// PARAMETERS
// - ADDR_W   6  byte/word address width; line address = ADDR_W-2 MSBs
// - WORD_W   32 word width; line width = 4*WORD_W
// - LATENCY  3  access-wait cycles before the first word read; legal range 1..15
// PORTS
// - clk      in  1        rising-edge clock
// - rst_n    in  1        asynchronous, active-low reset
// - req      in  1        fill request; sampled only while busy==0
// - req_addr in  ADDR_W   requested address; bits [1:0] ignored (line aligned)
// - busy     out 1        fill in progress; new req ignored
// - rvalid   out 1        one-cycle pulse; rdata holds a complete line
// - rdata    out 4*WORD_W filled line; word0 in [127:96], word3 in [31:0]
// - wr_en    in  1        word write strobe
// - wr_addr  in  ADDR_W   word address for write
// - wr_data  in  WORD_W   write data
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; busy=0, rvalid=0, rdata=0.
//   - Word counter and wait counter = 0.
//   - All 2^ADDR_W memory words = 0.
// - FSM states: IDLE, WAIT, READ, DONE.
//   - IDLE: req=1 at edge -> latch req_addr[5:2]; cnt=LATENCY-1; go WAIT.
//   - WAIT: cnt==0 -> go READ, widx=0; else cnt--. Occupies exactly LATENCY cycles.
//   - READ: each edge writes mem[{line,widx}] into rdata slot widx (slot0=[127:96]); widx++.
//     - After widx==3 -> go DONE.
//   - DONE: rvalid=1 for this cycle only.
//     - req=1 -> accepted exactly as in IDLE (back-to-back fills).
//     - Else -> IDLE.
// - Latency: req accepted at edge E0 -> rvalid high in the cycle after edge E0+LATENCY+4 (=7 at default).
// - busy=1 in WAIT and READ only; 0 in IDLE and DONE.
// - rdata holds its value from DONE until the next READ overwrites slot0.
// - req while busy: dropped, no queueing. Requester must hold or re-issue.
// - Writes:
//   - Accepted every cycle in any state, including during a fill.
//   - A write to a word of the line in flight that is not yet read is visible in the returned line.
//   - A write to a word already read is not visible.
//   - Same-edge write and read of one word: read returns the old data.
// - rst_n low mid-fill: fill aborts; no rvalid; outputs return to reset values immediately.
// - Address arithmetic: {line,widx} is ADDR_W bits; no wrap beyond the line.
// TESTING
// - Reset, then read line 0x0 (req_addr=6'h00) -> rvalid at edge 7, rdata=128'h0, busy high for 7 cycles.
// - Preload words 0x10..0x13 = 32'hA0..A3; req_addr=6'h12 -> rdata={A0,A1,A2,A3}; req_addr[1:0] ignored.
// - Issue req at busy=1 with req_addr=6'h20 -> ignored; only the original line returns; one rvalid pulse.
// - Hold req=1 through DONE with a new address -> second fill starts on the DONE edge; rvalid 7 cycles later.
// - wr_addr=6'h13, wr_data=32'hBEEF during WAIT of a line-0x10 fill -> rdata[31:0]=BEEF.
//   - Same write during the widx=3 read edge -> old A3 returned.
// - rst_n=0 during READ -> busy=0, rdata=0 immediately; no rvalid; memory cleared to 0.

Source files
------------

// File: rtl/line_fill_memory.sv
// line_fill_memory
//   Backing main memory for the 2-way set-associative cache and the cache's
//   fill source. A line request waits LATENCY cycles and then reads the four
//   words of the line, one per cycle. It returns them as one packed line with
//   a single-cycle rvalid pulse. A word-write port preloads and updates the
//   memory contents in any state, including while a fill is in progress.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst_n     in   1         asynchronous, active-low reset
//   req       in   1         fill request, sampled only while busy==0
//   req_addr  in   ADDR_W    requested address; bits [1:0] ignored
//   busy      out  1         fill in progress (WAIT/READ); new req ignored
//   rvalid    out  1         one-cycle pulse; rdata holds a complete line
//   rdata     out  4*WORD_W  filled line; word0 in the top slot
//   wr_en     in   1         word write strobe
//   wr_addr   in   ADDR_W    word address for write
//   wr_data   in   WORD_W    write data
module line_fill_memory #(
  parameter int ADDR_W  = 6,
  parameter int WORD_W  = 32,
  parameter int LATENCY = 3    // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  busy,
  output logic                  rvalid,
  output logic [4*WORD_W-1:0]   rdata,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WORD_W-1:0]     wr_data
);

  localparam int LINE_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [LINE_W-1:0]   line_q,  line_d;
  logic [1:0]          widx_q,  widx_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic [4*WORD_W-1:0] rdata_q, rdata_d;

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   rd_word;

  // The low address bits only select a word within the line; a fill always
  // returns the whole aligned line.
  logic unused_req_lsbs;
  assign unused_req_lsbs = ^req_addr[1:0];

  // The memory clears on reset, so it is built from flops rather than a RAM
  // macro. A write and a read of one word on the same edge return the old
  // word, because both take effect only after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_word = mem_q[{line_q, widx_q}];

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          line_d  = req_addr[ADDR_W-1:2];
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end

      // The counter starts at LATENCY-1, so WAIT lasts exactly LATENCY cycles.
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          widx_d  = 2'd0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // Word 0 lands in the top slot and word 3 in the bottom slot.
      S_READ: begin
        case (widx_q)
          2'd0:    rdata_d[4*WORD_W-1 -: WORD_W] = rd_word;
          2'd1:    rdata_d[3*WORD_W-1 -: WORD_W] = rd_word;
          2'd2:    rdata_d[2*WORD_W-1 -: WORD_W] = rd_word;
          default: rdata_d[WORD_W-1:0]           = rd_word;
        endcase
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd3) begin
          state_d = S_DONE;
        end
      end

      // A request held through DONE starts the next fill immediately.
      default: begin
        if (req) begin
          line_d  = req_addr[ADDR_W-1:2];
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      widx_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy   = (state_q == S_WAIT) || (state_q == S_READ);
  assign rvalid = (state_q == S_DONE);
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_line_fill_memory.sv
module tb_line_fill_memory;

  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req = 1'b0;
  logic [5:0]   req_addr = '0;
  logic         busy;
  logic         rvalid;
  logic [127:0] rdata;
  logic         wr_en = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  localparam logic [127:0] LINE_A  = 128'h000000A0_000000A1_000000A2_000000A3;
  localparam logic [127:0] LINE_C  = 128'h000000C0_000000C1_000000C2_000000C3;
  localparam logic [127:0] LINE_AB = 128'h000000A0_000000A1_000000A2_0000BEEF;

  line_fill_memory #(.ADDR_W(6), .WORD_W(32), .LATENCY(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .busy     (busy),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A fill accepted at edge E0 is tracked as a phase count of edges since E0.
  // Word i is sampled from memory at phase L+1+i, before that edge's write
  // lands. busy covers phases 0..L+3 and rvalid is phase L+4.
  logic [31:0]  mmem [64];
  bit           m_active;
  int           m_phase;
  logic [3:0]   m_line;
  logic [127:0] m_rdata;
  logic         exp_busy, exp_rvalid;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mmem[i] = '0;
    m_active = 1'b0;
    m_phase = 0;
    m_line = '0;
    m_rdata = '0;
    exp_busy = 1'b0;
    exp_rvalid = 1'b0;
  endtask

  task automatic model_step();
    logic       busy_prev;
    int         wi;
    logic [1:0] w2;
    busy_prev = exp_busy;
    if (m_active) begin
      m_phase++;
      if (m_phase >= L + 1 && m_phase <= L + 4) begin
        wi = m_phase - L - 1;
        w2 = wi[1:0];
        m_rdata[(3 - wi) * 32 +: 32] = mmem[{m_line, w2}];
      end
      if (m_phase > L + 4) m_active = 1'b0;
    end
    if (wr_en) mmem[wr_addr] = wr_data;
    if (req && !busy_prev) begin
      m_active = 1'b1;
      m_phase = 0;
      m_line = req_addr[5:2];
    end
    exp_busy   = m_active && (m_phase <= L + 3);
    exp_rvalid = m_active && (m_phase == L + 4);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("cyc_busy",   {127'd0, busy},   {127'd0, exp_busy});
        chk("cyc_rvalid", {127'd0, rvalid}, {127'd0, exp_rvalid});
        chk("cyc_rdata",  rdata, m_rdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Caller is just past the accept edge (or later). Counts negedges until
  // rvalid, along with how many of those showed busy.
  task automatic wait_line(input string name, input int exp_n, input logic [127:0] exp_d);
    int n = 0;
    int bc = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rvalid) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      n++;
    end
    chk({name, "_seen"}, {127'd0, seen}, 128'd1);
    if (exp_n >= 0) begin
      chk({name, "_latency"}, 128'(n), 128'(exp_n));
      chk({name, "_busycyc"}, 128'(bc), 128'(exp_n));
    end
    chk({name, "_data"}, rdata, exp_d);
  endtask

  task automatic count_rvalid(input string name, input int cycles);
    int pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (rvalid) pulses++;
    end
    chk(name, 128'(pulses), 128'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",   {127'd0, busy},   128'd0);
    chk("reset_rvalid", {127'd0, rvalid}, 128'd0);
    chk("reset_rdata",  rdata, 128'd0);
    rst_n = 1'b1;
    step();

    // Line 0 from cleared memory.
    $display("txn fill line 0x00");
    req = 1'b1; req_addr = 6'h00;
    step();
    req = 1'b0;
    wait_line("fill0", 7, 128'd0);

    // Preload lines 0x10 and 0x20.
    for (int i = 0; i < 4; i++) wr(6'h10 + 6'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) wr(6'h20 + 6'(i), 32'hC0 + 32'(i));
    $display("txn preload lines 0x10 and 0x20");

    // Unaligned request address returns the aligned line.
    $display("txn fill req_addr 0x12");
    req = 1'b1; req_addr = 6'h12;
    step();
    req = 1'b0;
    wait_line("fill12", 7, LINE_A);

    // Request while busy is dropped.
    $display("txn req 0x20 while busy");
    req = 1'b1; req_addr = 6'h10;
    step();
    req = 1'b0;
    step();
    req = 1'b1; req_addr = 6'h20;
    step();
    req = 1'b0;
    wait_line("dropreq", 5, LINE_A);
    count_rvalid("dropreq_extra_rvalid", 15);

    // Back-to-back fills with req held through DONE.
    $display("txn back-to-back 0x10 then 0x20");
    req = 1'b1; req_addr = 6'h10;
    step();
    req_addr = 6'h20;
    wait_line("b2b_first", 7, LINE_A);
    step();
    req = 1'b0;
    wait_line("b2b_second", 7, LINE_C);

    // Write to an unread word during WAIT is visible.
    $display("txn write 0x13 during WAIT");
    req = 1'b1; req_addr = 6'h10;
    step();
    req = 1'b0;
    wr_en = 1'b1; wr_addr = 6'h13; wr_data = 32'hBEEF;
    step();
    wr_en = 1'b0;
    wait_line("wr_wait", 6, LINE_AB);
    wr(6'h13, 32'hA3);

    // Write on the same edge that reads word 3 is not visible.
    $display("txn write 0x13 on word-3 read edge");
    req = 1'b1; req_addr = 6'h10;
    step();
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 6'h13; wr_data = 32'hBEEF;
    step();
    wr_en = 1'b0;
    wait_line("wr_same_edge", -1, LINE_A);

    // Reset in the middle of READ.
    $display("txn reset during READ");
    req = 1'b1; req_addr = 6'h10;
    step();
    req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("midread_rdata_nonzero", {127'd0, (rdata != 128'd0)}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {127'd0, busy},   128'd0);
    chk("midrst_rvalid", {127'd0, rvalid}, 128'd0);
    chk("midrst_rdata",  rdata, 128'd0);
    step();
    rst_n = 1'b1;
    count_rvalid("midrst_no_rvalid", 12);

    $display("txn fill 0x10 after reset");
    req = 1'b1; req_addr = 6'h10;
    step();
    req = 1'b0;
    wait_line("post_reset", 7, 128'd0);

    step();
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
